// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage hazard/flush controller: a load scoreboard gives RAW/WAW/capacity stalls,
// and a redirect opens a fixed-length flush window over the decode pipe.
module pipe_hazard_ctrl #(
   parameter int unsigned MAX_PENDING   = 4,
   parameter int unsigned FLUSH_CYCLES  = 2,
   parameter int unsigned STALL_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       issue_valid,
   input  logic [4:0] issue_rs1,
   input  logic [4:0] issue_rs2,
   input  logic       issue_use_rs1,
   input  logic       issue_use_rs2,
   input  logic [4:0] issue_rd,
   input  logic       issue_is_load,
   input  logic       wb_valid,
   input  logic [4:0] wb_rd,
   input  logic       redirect,
   output logic       stall,
   output logic       flush,
   output logic       issue_fire,
   output logic [4:0] pending_cnt,
   output logic       err_spurious,
   output logic       stall_timeout
);

   localparam int unsigned NREG    = 32;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned STALL_W = 8;
   localparam int unsigned FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t              state, state_nxt;
   logic [FC_W-1:0]     flush_cnt, flush_cnt_nxt;

   logic [NREG-1:0]     sb, sb_nxt;
   logic [NREG-1:0]     clr_mask, set_mask, eff;
   logic [CNT_W-1:0]    pending_cnt_eff, pending_cnt_nxt;
   logic [STALL_W-1:0]  stall_cnt, stall_cnt_nxt;

   logic                clr_valid, set_valid, wb_spurious;
   logic                haz_rs1, haz_rs2, haz_rd, haz_cap, hazard;
   logic                in_run;

   // Same-cycle writeback resolves the hazard it clears
   assign clr_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
   assign eff       = sb & ~clr_mask;
   assign clr_valid = wb_valid & sb[wb_rd];
   assign wb_spurious = wb_valid & ~sb[wb_rd];

   assign pending_cnt_eff = pending_cnt - CNT_W'(clr_valid);

   assign haz_rs1 = issue_use_rs1 & eff[issue_rs1];
   assign haz_rs2 = issue_use_rs2 & eff[issue_rs2];
   assign haz_rd  = (issue_rd != 5'd0) & eff[issue_rd];
   assign haz_cap = issue_is_load & (issue_rd != 5'd0) &
                    (pending_cnt_eff == CNT_W'(MAX_PENDING));
   assign hazard  = issue_valid & (haz_rs1 | haz_rs2 | haz_rd | haz_cap);

   assign in_run     = (state == RUN);
   assign stall      = hazard & in_run;
   assign flush      = (state == FLUSH);
   assign issue_fire = issue_valid & ~stall & ~flush;

   assign set_valid = issue_fire & issue_is_load & (issue_rd != 5'd0);
   assign set_mask  = set_valid ? (NREG'(1) << issue_rd) : '0;

   // Set wins over a same-cycle clear; x0 never becomes pending
   assign sb_nxt = ((sb & ~clr_mask) | set_mask) & ~NREG'(1);

   assign pending_cnt_nxt = pending_cnt + CNT_W'(set_valid) - CNT_W'(clr_valid);

   assign stall_cnt_nxt = !stall ? '0 :
                          (stall_cnt == '1) ? stall_cnt : stall_cnt + STALL_W'(1);

   // Flush sequencer state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= RUN;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         flush_cnt <= flush_cnt_nxt;
      end
   end

   // Flush sequencer next state; a redirect inside the window restarts it
   always_comb begin
      state_nxt     = state;
      flush_cnt_nxt = flush_cnt;
      case (state)
         RUN: begin
            if (redirect) begin
               state_nxt     = FLUSH;
               flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (redirect) begin
               flush_cnt_nxt = FC_W'(FLUSH_CYCLES - 1);
            end else if (flush_cnt == '0) begin
               state_nxt = RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - FC_W'(1);
            end
         end
         default: begin
            state_nxt     = RUN;
            flush_cnt_nxt = '0;
         end
      endcase
   end

   // Scoreboard, occupancy, stall watchdog and sticky error flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sb            <= '0;
         pending_cnt   <= '0;
         stall_cnt     <= '0;
         err_spurious  <= 1'b0;
         stall_timeout <= 1'b0;
      end else begin
         sb          <= sb_nxt;
         pending_cnt <= pending_cnt_nxt;
         stall_cnt   <= stall_cnt_nxt;
         if (wb_spurious) begin
            err_spurious <= 1'b1;
         end
         if (stall && (stall_cnt == STALL_W'(STALL_TIMEOUT))) begin
            stall_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: per-cycle comparison against a register-table model
// plus hand-computed spot checks.
module tb_pipe_hazard_ctrl;

   localparam int unsigned MAXP = 4;
   localparam int unsigned FC   = 2;
   localparam int unsigned TMO  = 255;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       issue_valid, issue_use_rs1, issue_use_rs2, issue_is_load;
   logic [4:0] issue_rs1, issue_rs2, issue_rd;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       redirect;
   logic       stall, flush, issue_fire, err_spurious, stall_timeout;
   logic [4:0] pending_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   pipe_hazard_ctrl #(
      .MAX_PENDING  (MAXP),
      .FLUSH_CYCLES (FC),
      .STALL_TIMEOUT(TMO)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .issue_valid  (issue_valid),
      .issue_rs1    (issue_rs1),
      .issue_rs2    (issue_rs2),
      .issue_use_rs1(issue_use_rs1),
      .issue_use_rs2(issue_use_rs2),
      .issue_rd     (issue_rd),
      .issue_is_load(issue_is_load),
      .wb_valid     (wb_valid),
      .wb_rd        (wb_rd),
      .redirect     (redirect),
      .stall        (stall),
      .flush        (flush),
      .issue_fire   (issue_fire),
      .pending_cnt  (pending_cnt),
      .err_spurious (err_spurious),
      .stall_timeout(stall_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model: pending table, sticky flags, last redirect cycle
   bit pend [32];
   bit m_err, m_tmo;
   int srun;
   int last_redir;
   int cyc = 0;

   function automatic int count_pend();
      int n = 0;
      for (int r = 0; r < 32; r++) n += int'(pend[r]);
      return n;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         for (int r = 0; r < 32; r++) pend[r] = 1'b0;
         m_err = 1'b0;
         m_tmo = 1'b0;
         srun = 0;
         last_redir = -100;
         chk("rst_stall", 32'(stall), 0);
         chk("rst_flush", 32'(flush), 0);
         chk("rst_fire", 32'(issue_fire), 0);
         chk("rst_pend", 32'(pending_cnt), 0);
         chk("rst_err", 32'(err_spurious), 0);
         chk("rst_tmo", 32'(stall_timeout), 0);
      end else begin
         int  d, cnt_after;
         bit  wbhit, e_flush, e_stall, e_fire, haz;
         bit  av1, av2, avd;
         d         = cyc - last_redir;
         e_flush   = (d >= 1) && (d <= int'(FC));
         wbhit     = wb_valid && pend[wb_rd];
         cnt_after = count_pend() - int'(wbhit);
         av1 = pend[issue_rs1] && !(wbhit && wb_rd == issue_rs1);
         av2 = pend[issue_rs2] && !(wbhit && wb_rd == issue_rs2);
         avd = pend[issue_rd]  && !(wbhit && wb_rd == issue_rd);
         haz = issue_valid && ((issue_use_rs1 && av1) || (issue_use_rs2 && av2) ||
                               (issue_rd != 0 && avd) ||
                               (issue_is_load && issue_rd != 0 && cnt_after >= int'(MAXP)));
         e_stall = haz && !e_flush;
         e_fire  = issue_valid && !e_stall && !e_flush;

         chk("stall", 32'(stall), 32'(e_stall));
         chk("flush", 32'(flush), 32'(e_flush));
         chk("fire", 32'(issue_fire), 32'(e_fire));
         chk("pending_cnt", 32'(pending_cnt), 32'(count_pend()));
         chk("err_spurious", 32'(err_spurious), 32'(m_err));
         chk("stall_timeout", 32'(stall_timeout), 32'(m_tmo));

         if (wb_valid) begin
            if (wbhit) pend[wb_rd] = 1'b0;
            else       m_err = 1'b1;
         end
         if (e_fire && issue_is_load && issue_rd != 0) pend[issue_rd] = 1'b1;
         if (e_stall) begin
            srun++;
            if (srun > int'(TMO)) m_tmo = 1'b1;
         end else begin
            srun = 0;
         end
         if (redirect) last_redir = cyc;
      end
      cyc++;
   end

   // ---------------- stimulus helpers
   task automatic clr_in();
      issue_valid = 0; issue_use_rs1 = 0; issue_use_rs2 = 0; issue_is_load = 0;
      issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
      wb_valid = 0; wb_rd = 0; redirect = 0;
   endtask

   task automatic iss(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic u1, input logic u2, input logic ld);
      issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
      issue_use_rs1 = u1; issue_use_rs2 = u2; issue_is_load = ld;
   endtask

   task automatic wb(input logic [4:0] r);
      wb_valid = 1; wb_rd = r;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clr_in();
   endtask

   initial begin
      clr_in();
      reset_n = 0;
      step(); step();
      reset_n = 1;

      // Load x5, then dependent ADD stalls until the writeback cycle
      iss(5'd10, 5'd0, 5'd5, 1, 0, 1);
      @(negedge clk); chk("t1_load_fire", 32'(issue_fire), 1);
      step();
      iss(5'd5, 5'd0, 5'd7, 1, 0, 0);
      @(negedge clk); chk("t1_stall", 32'(stall), 1); chk("t1_pend", 32'(pending_cnt), 1);
      step();
      iss(5'd5, 5'd0, 5'd7, 1, 0, 0);
      @(negedge clk); chk("t1_stall2", 32'(stall), 1);
      step();
      iss(5'd5, 5'd0, 5'd7, 1, 0, 0); wb(5'd5);
      @(negedge clk); chk("t1_wb_fire", 32'(issue_fire), 1); chk("t1_wb_stall", 32'(stall), 0);
      step();
      @(negedge clk); chk("t1_pend0", 32'(pending_cnt), 0);
      step();

      // Load to x0 never marks anything pending
      iss(5'd0, 5'd0, 5'd0, 0, 0, 1);
      step();
      iss(5'd0, 5'd0, 5'd3, 1, 0, 0);
      @(negedge clk); chk("t2_pend", 32'(pending_cnt), 0); chk("t2_fire", 32'(issue_fire), 1);
      step();

      // Capacity: four loads outstanding, fifth stalls unless a writeback frees a slot
      for (int r = 1; r <= 4; r++) begin
         iss(5'd0, 5'd0, 5'(r), 0, 0, 1);
         step();
      end
      iss(5'd0, 5'd0, 5'd6, 0, 0, 1);
      @(negedge clk); chk("t3_pend4", 32'(pending_cnt), 4); chk("t3_cap_stall", 32'(stall), 1);
      step();
      iss(5'd0, 5'd0, 5'd6, 0, 0, 1); wb(5'd2);
      @(negedge clk); chk("t3_cap_fire", 32'(issue_fire), 1);
      step();
      @(negedge clk); chk("t3_pend_still4", 32'(pending_cnt), 4);
      step();
      wb(5'd1); step();
      wb(5'd3); step();
      wb(5'd4); step();
      wb(5'd6); step();
      @(negedge clk); chk("t3_drained", 32'(pending_cnt), 0);
      step();

      // Spurious writeback is sticky and leaves occupancy alone
      wb(5'd9);
      step();
      @(negedge clk); chk("t5_err", 32'(err_spurious), 1); chk("t5_pend", 32'(pending_cnt), 0);
      step();

      // Redirect at T, second at T+1: flush T+1..T+3; writeback during flush still clears
      iss(5'd0, 5'd0, 5'd8, 0, 0, 1);
      step();
      iss(5'd1, 5'd0, 5'd11, 1, 0, 0); redirect = 1;
      @(negedge clk); chk("t4_T_flush", 32'(flush), 0); chk("t4_T_fire", 32'(issue_fire), 1);
      step();
      iss(5'd8, 5'd0, 5'd11, 1, 0, 0); redirect = 1;
      @(negedge clk); chk("t4_T1_flush", 32'(flush), 1); chk("t4_T1_fire", 32'(issue_fire), 0);
      chk("t4_T1_stall", 32'(stall), 0);
      step();
      wb(5'd8); iss(5'd1, 5'd0, 5'd11, 1, 0, 0);
      @(negedge clk); chk("t4_T2_flush", 32'(flush), 1);
      step();
      iss(5'd1, 5'd0, 5'd11, 1, 0, 0);
      @(negedge clk); chk("t4_T3_flush", 32'(flush), 1); chk("t4_T3_pend", 32'(pending_cnt), 0);
      step();
      iss(5'd1, 5'd0, 5'd11, 1, 0, 0);
      @(negedge clk); chk("t4_T4_flush", 32'(flush), 0); chk("t4_T4_fire", 32'(issue_fire), 1);
      step();

      // Stall watchdog, then asynchronous reset in the middle of the stall
      iss(5'd0, 5'd0, 5'd12, 0, 0, 1);
      step();
      for (int k = 1; k <= 258; k++) begin
         iss(5'd12, 5'd0, 5'd13, 1, 0, 0);
         @(negedge clk);
         if (k == 256) chk("t6_tmo_before", 32'(stall_timeout), 0);
         if (k == 257) chk("t6_tmo_set", 32'(stall_timeout), 1);
         step();
      end
      iss(5'd12, 5'd0, 5'd13, 1, 0, 0);
      #2;
      reset_n = 0;
      clr_in();
      #1;
      chk("t6_async_stall", 32'(stall), 0);
      chk("t6_async_tmo", 32'(stall_timeout), 0);
      chk("t6_async_err", 32'(err_spurious), 0);
      chk("t6_async_pend", 32'(pending_cnt), 0);
      chk("t6_async_fire", 32'(issue_fire), 0);
      chk("t6_async_flush", 32'(flush), 0);
      step(); step();
      reset_n = 1;
      wb(5'd12);
      step();
      @(negedge clk); chk("t6_post_rst_err", 32'(err_spurious), 1);
      chk("t6_post_rst_pend", 32'(pending_cnt), 0);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
